// File: rtl/tableau_stream_ctrl.sv
// tableau_stream_ctrl
//   Queues decoded memory ops from the CPU side, executes them against an on-chip
//   tableau RAM and forwards operands to the accelerator. Accelerator results are
//   committed back with STORE ops; read-after-write hazards are resolved in hardware.
//   Pipeline: input FIFO -> EX (RAM read issue) -> WB (forward / RAM write).
//
// Build option:
//   TABLEAU_RAW_BYPASS_EN  defined: a LOAD in EX that hits the STORE in WB takes the
//                          store data through a bypass mux, with no stall.
//                          undefined: that LOAD waits one cycle in EX (bubble in WB)
//                          and re-reads the RAM after the store has committed.
//
// Ports:
//   clk          clock
//   rst_n        asynchronous reset, asserted HIGH (existing codebase polarity)
//   flush_i      synchronous flush of FIFO, EX and WB; RAM contents kept
//   in_valid_i   op valid             in_ready_o  FIFO not full (0 while in reset)
//   in_op_i      00 NOP, 01 LOAD, 10 IMM, 11 STORE
//   in_addr_i    RAM address (LOAD/STORE)
//   in_data_i    immediate (IMM) or store data (STORE)
//   fwd_data_o   operand to accelerator (0 when fwd_valid_o is low)
//   fwd_valid_o  operand valid        fwd_ready_i accelerator accepts operand
//   err_o        one-cycle pulse when an out-of-range LOAD/STORE reaches WB
//   level_o      FIFO occupancy       busy_o      any op in FIFO, EX or WB
//   dbg_addr_i   debug read address   dbg_data_o  RAM[dbg_addr_i], combinational

module tableau_stream_ctrl #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_DEPTH  = 64,
    parameter int unsigned ADDR_W     = $clog2(MEM_DEPTH),
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush_i,
    input  logic                             in_valid_i,
    output logic                             in_ready_o,
    input  logic [1:0]                       in_op_i,
    input  logic [ADDR_W-1:0]                in_addr_i,
    input  logic [DATA_W-1:0]                in_data_i,
    output logic [DATA_W-1:0]                fwd_data_o,
    output logic                             fwd_valid_o,
    input  logic                             fwd_ready_i,
    output logic                             err_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  level_o,
    output logic                             busy_o,
    input  logic [ADDR_W-1:0]                dbg_addr_i,
    output logic [DATA_W-1:0]                dbg_data_o
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        OpNop   = 2'b00,
        OpLoad  = 2'b01,
        OpImm   = 2'b10,
        OpStore = 2'b11
    } op_e;

    // Tableau RAM (not reset)
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    // Input FIFO
    op_e               fifo_op   [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  count_q;

    // EX stage
    logic              ex_valid_q;
    op_e               ex_op_q;
    logic [ADDR_W-1:0] ex_addr_q;
    logic [DATA_W-1:0] ex_data_q;

    // WB stage; wb_first_q marks the first cycle an op sits in WB
    logic              wb_valid_q;
    op_e               wb_op_q;
    logic [ADDR_W-1:0] wb_addr_q;
    logic [DATA_W-1:0] wb_data_q;
    logic              wb_first_q;

    logic              fifo_full, fifo_empty;
    logic              push, pop;
    logic              ex_in_range, wb_in_range;
    logic              wb_fwd, wb_hold, mem_we, raw_hit;
    logic              ex_adv, ex_free;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] wb_data_d;

    assign fifo_full  = (count_q == LVL_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);

    // Ready is forced low while reset is asserted so every output reads 0.
    assign in_ready_o = ~rst_n & ~fifo_full;
    assign push       = in_valid_i & in_ready_o & (in_op_i != OpNop) & ~flush_i;

    assign ex_in_range = (32'(ex_addr_q) < MEM_DEPTH);
    assign wb_in_range = (32'(wb_addr_q) < MEM_DEPTH);

    assign wb_fwd  = wb_valid_q & (wb_op_q != OpStore);
    assign wb_hold = wb_fwd & ~fwd_ready_i;
    assign mem_we  = wb_valid_q & (wb_op_q == OpStore) & wb_in_range;

    // LOAD in EX reading the word that the STORE in WB writes at this edge.
    assign raw_hit = ex_valid_q & (ex_op_q == OpLoad) & ex_in_range & mem_we &
                     (wb_addr_q == ex_addr_q);

`ifdef TABLEAU_RAW_BYPASS_EN
    assign ex_adv = ex_valid_q & ~wb_hold;
`else
    assign ex_adv = ex_valid_q & ~wb_hold & ~raw_hit;
`endif

    assign ex_free = ~ex_valid_q | ex_adv;
    assign pop     = ~fifo_empty & ex_free & ~flush_i;

    // Synchronous RAM read issued from EX, captured into WB.
    always_comb begin
        ld_data = '0;
        if (ex_in_range) begin
            ld_data = mem[ex_addr_q];
        end
`ifdef TABLEAU_RAW_BYPASS_EN
        if (raw_hit) begin
            ld_data = wb_data_q;
        end
`endif
    end

    always_comb begin
        wb_data_d = ex_data_q;
        if (ex_op_q == OpLoad) begin
            wb_data_d = ld_data;
        end
    end

    // FIFO storage, no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op[wr_ptr_q]   <= op_e'(in_op_i);
            fifo_addr[wr_ptr_q] <= in_addr_i;
            fifo_data[wr_ptr_q] <= in_data_i;
        end
    end

    // RAM write; a STORE in WB commits even during a flush
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wb_addr_q] <= wb_data_q;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ex_valid_q <= 1'b0;
            ex_op_q    <= OpNop;
            ex_addr_q  <= '0;
            ex_data_q  <= '0;
            wb_valid_q <= 1'b0;
            wb_op_q    <= OpNop;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            wb_first_q <= 1'b0;
        end else if (flush_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ex_valid_q <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_first_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + LVL_W'(1);
                2'b01:   count_q <= count_q - LVL_W'(1);
                default: count_q <= count_q;
            endcase

            if (ex_free) begin
                ex_valid_q <= pop;
                if (pop) begin
                    ex_op_q   <= fifo_op[rd_ptr_q];
                    ex_addr_q <= fifo_addr[rd_ptr_q];
                    ex_data_q <= fifo_data[rd_ptr_q];
                end
            end

            // WB takes the EX op, or a bubble when EX is empty or hazard-held.
            if (!wb_hold) begin
                wb_valid_q <= ex_adv;
                if (ex_adv) begin
                    wb_op_q   <= ex_op_q;
                    wb_addr_q <= ex_addr_q;
                    wb_data_q <= wb_data_d;
                end
            end
            wb_first_q <= ex_adv;
        end
    end

    // Out-of-range LOAD forwards 0: ld_data is 0 in that case.
    assign fwd_valid_o = wb_fwd;
    assign fwd_data_o  = wb_fwd ? wb_data_q : '0;
    assign err_o       = wb_valid_q & wb_first_q & ~wb_in_range & (wb_op_q != OpImm);
    assign level_o     = count_q;
    assign busy_o      = ~fifo_empty | ex_valid_q | wb_valid_q;
    assign dbg_data_o  = (32'(dbg_addr_i) < MEM_DEPTH) ? mem[dbg_addr_i] : '0;

endmodule

// File: tb/tb_tableau_stream_ctrl.sv
// Bench for tableau_stream_ctrl (MEM_DEPTH=48 so addresses 48/49 are out of range).
// A queue model predicts every forwarded operand from the ops accepted so far;
// directed checks pin latency, levels, flush, reset and error pulses.

module tb_tableau_stream_ctrl;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned MEM_DEPTH  = 48;
    localparam int unsigned ADDR_W     = 6;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned LVL_W      = 3;

    localparam logic [1:0] NOP = 2'b00, LOAD = 2'b01, IMM = 2'b10, STORE = 2'b11;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              flush_i = 1'b0;
    logic              in_valid_i = 1'b0;
    logic              in_ready_o;
    logic [1:0]        in_op_i = 2'b00;
    logic [ADDR_W-1:0] in_addr_i = '0;
    logic [DATA_W-1:0] in_data_i = '0;
    logic [DATA_W-1:0] fwd_data_o;
    logic              fwd_valid_o;
    logic              fwd_ready_i = 1'b1;
    logic              err_o;
    logic [LVL_W-1:0]  level_o;
    logic              busy_o;
    logic [ADDR_W-1:0] dbg_addr_i = '0;
    logic [DATA_W-1:0] dbg_data_o;

    tableau_stream_ctrl #(
        .DATA_W     (DATA_W),
        .MEM_DEPTH  (MEM_DEPTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_op_i     (in_op_i),
        .in_addr_i   (in_addr_i),
        .in_data_i   (in_data_i),
        .fwd_data_o  (fwd_data_o),
        .fwd_valid_o (fwd_valid_o),
        .fwd_ready_i (fwd_ready_i),
        .err_o       (err_o),
        .level_o     (level_o),
        .busy_o      (busy_o),
        .dbg_addr_i  (dbg_addr_i),
        .dbg_data_o  (dbg_data_o)
    );

    always #5 clk = ~clk;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    int err_seen = 0;
    int err_exp  = 0;
    int cyc      = 0;

    logic [31:0] exp_q [$];
    logic [31:0] mram [MEM_DEPTH];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Model + compare: one process, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_q.delete();
        end else begin
            if (fwd_valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("fwd_unexpected_valid", 32'(fwd_valid_o), 32'd0);
                end else begin
                    chk("fwd_data", fwd_data_o, exp_q[0]);
                    if (fwd_ready_i) void'(exp_q.pop_front());
                end
            end
            if (err_o) err_seen++;
            if (flush_i) begin
                exp_q.delete();
            end else if (in_valid_i && in_ready_o) begin
                int a;
                a = int'(in_addr_i);
                case (in_op_i)
                    LOAD: begin
                        if (a < MEM_DEPTH) exp_q.push_back(mram[a]);
                        else begin exp_q.push_back(32'd0); err_exp++; end
                    end
                    IMM:  exp_q.push_back(in_data_i);
                    STORE: begin
                        if (a < MEM_DEPTH) mram[a] = in_data_i;
                        else err_exp++;
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] op, input int addr, input logic [31:0] data);
        logic acc;
        acc = 1'b0;
        in_valid_i = 1'b1;
        in_op_i    = op;
        in_addr_i  = addr[ADDR_W-1:0];
        in_data_i  = data;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            acc = in_ready_o;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) chk("push_timeout", 32'(acc), 32'd1);
        in_valid_i = 1'b0;
        in_op_i    = NOP;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_o && n < 60) begin
            tick();
            n++;
        end
        if (busy_o) chk("idle_timeout", 32'(busy_o), 32'd0);
    endtask

    initial begin
        int n;
        int e0;
        int c0;
        int exp_lat;

        // Reset state (reset asserted high)
        repeat (2) tick();
        chk("rst_fwd_valid", 32'(fwd_valid_o), 32'd0);
        chk("rst_err",       32'(err_o),       32'd0);
        chk("rst_level",     32'(level_o),     32'd0);
        chk("rst_busy",      32'(busy_o),      32'd0);
        chk("rst_ready_low", 32'(in_ready_o),  32'd0);
        rst_n = 1'b0;
        #1;
        chk("rel_ready", 32'(in_ready_o), 32'd1);
        tick();

        // IMM latency: accepted cycle t -> fwd_valid at t+3
        fwd_ready_i = 1'b1;
        push(IMM, 9, 32'h3F80_0000);             // now cycle t+1
        chk("imm_t1_level", 32'(level_o),     32'd1);
        chk("imm_t1_valid", 32'(fwd_valid_o), 32'd0);
        tick();                                   // t+2
        chk("imm_t2_level", 32'(level_o),     32'd0);
        chk("imm_t2_busy",  32'(busy_o),      32'd1);
        chk("imm_t2_valid", 32'(fwd_valid_o), 32'd0);
        tick();                                   // t+3
        chk("imm_t3_valid", 32'(fwd_valid_o), 32'd1);
        chk("imm_t3_data",  fwd_data_o,       32'h3F80_0000);
        chk("imm_t3_err",   32'(err_o),       32'd0);
        tick();
        chk("imm_t4_busy",  32'(busy_o),      32'd0);

        // NOP is accepted and discarded
        push(NOP, 0, 32'hFFFF_FFFF);
        chk("nop_level", 32'(level_o), 32'd0);
        chk("nop_busy",  32'(busy_o),  32'd0);

        // Preload words used later
        push(STORE, 1, 32'h1111_1111);
        for (int i = 10; i < 16; i++) push(STORE, i, 32'h4000_0000 + 32'(i));
        wait_idle();

        // STORE then LOAD same address, back to back
`ifdef TABLEAU_RAW_BYPASS_EN
        exp_lat = 3;
`else
        exp_lat = 4;
`endif
        push(STORE, 3, 32'h4150_0000);
        push(LOAD, 3, 32'h0);                     // now cycle L+1
        n = 1;
        while (!fwd_valid_o && n < 10) begin
            tick();
            n++;
        end
        chk("raw_latency", 32'(n),     32'(exp_lat));
        chk("raw_data",    fwd_data_o, 32'h4150_0000);
        wait_idle();

        // 6 LOADs with the accelerator stalled: FIFO fills, head operand held
        fwd_ready_i = 1'b0;
        for (int i = 10; i < 16; i++) push(LOAD, i, 32'h0);
        chk("stall_level", 32'(level_o),    32'd4);
        chk("stall_ready", 32'(in_ready_o), 32'd0);
        chk("stall_valid", 32'(fwd_valid_o), 32'd1);
        chk("stall_data",  fwd_data_o,      32'h4000_000A);
        tick();
        chk("stall_held",  fwd_data_o,      32'h4000_000A);
        chk("stall_level2", 32'(level_o),   32'd4);
        fwd_ready_i = 1'b1;
        wait_idle();
        chk("stall_drained", 32'(exp_q.size()), 32'd0);

        // Out-of-range LOAD and STORE
        e0 = err_seen;
        push(LOAD, MEM_DEPTH, 32'h0);
        push(STORE, MEM_DEPTH + 1, 32'hDEAD_0001);
        wait_idle();
        tick();
        chk("oor_err_pulses", 32'(err_seen - e0), 32'd2);
        dbg_addr_i = 6'd1;
        #1;
        chk("oor_ram1", dbg_data_o, 32'h1111_1111);
        dbg_addr_i = 6'd3;
        #1;
        chk("oor_ram3", dbg_data_o, 32'h4150_0000);

        // Flush with FIFO=3 and a STORE in WB
        fwd_ready_i = 1'b0;
        push(IMM, 0, 32'h1234_5678);
        push(STORE, 5, 32'hC198_0000);
        for (int i = 0; i < 4; i++) push(LOAD, 3, 32'h0);
        chk("fl_level4", 32'(level_o), 32'd4);
        fwd_ready_i = 1'b1;                       // IMM leaves, STORE reaches WB
        tick();
        fwd_ready_i = 1'b0;
        chk("fl_level3", 32'(level_o), 32'd3);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("fl_level0", 32'(level_o),     32'd0);
        chk("fl_busy0",  32'(busy_o),      32'd0);
        chk("fl_valid0", 32'(fwd_valid_o), 32'd0);
        dbg_addr_i = 6'd5;
        #1;
        chk("fl_ram5", dbg_data_o, 32'hC198_0000);

        // Reset while an operand is pending
        push(IMM, 0, 32'hDEAD_BEEF);
        push(LOAD, 3, 32'h0);
        n = 0;
        while (!fwd_valid_o && n < 10) begin
            tick();
            n++;
        end
        chk("pre_rst_valid", 32'(fwd_valid_o), 32'd1);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(fwd_valid_o), 32'd0);
        chk("mid_rst_data",  fwd_data_o,       32'd0);
        chk("mid_rst_level", 32'(level_o),     32'd0);
        chk("mid_rst_busy",  32'(busy_o),      32'd0);
        chk("mid_rst_ready", 32'(in_ready_o),  32'd0);
        chk("mid_rst_err",   32'(err_o),       32'd0);
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        chk("post_rst_ready", 32'(in_ready_o), 32'd1);
        tick();

        // Throughput: 8 IMMs in 8 cycles with fwd_ready=1
        fwd_ready_i = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 8; i++) push(IMM, 0, 32'hA000_0000 + 32'(i));
        chk("thru_cycles", 32'(cyc - c0), 32'd8);
        wait_idle();
        tick();
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("final_err_count",   32'(err_seen),     32'(err_exp));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
